// File: rtl/param_translation_table.sv
// param_translation_table: lookup table of {CT address, mask} entries with per-entry valid bits and a power-up clear sweep
//   params : ADDR_W (index width, DEPTH = 2**ADDR_W), CT_W (CT address width), MASK_W (mask width)
//   inputs : clk, rst (async, active-high), read/write/invalidate strobes on shared address, CT_address_in/Mask_in write data
//   outputs: ready (table accepting requests), CT_read (one-cycle result strobe), CT_address/Mask/hit (held lookup result)
module param_translation_table #(
  parameter int ADDR_W = 12,
  parameter int CT_W   = 11,
  parameter int MASK_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic              invalidate,
  input  logic [ADDR_W-1:0] address,
  input  logic [CT_W-1:0]   CT_address_in,
  input  logic [MASK_W-1:0] Mask_in,
  output logic              ready,
  output logic              CT_read,
  output logic [CT_W-1:0]   CT_address,
  output logic [MASK_W-1:0] Mask,
  output logic              hit
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DEPTH-1:0]    r_valid;
  logic [CT_W-1:0]     r_ct_mem [DEPTH];
  logic [MASK_W-1:0]   r_mask_mem [DEPTH];
  logic                w_run, w_rd, w_wr, w_inv, w_hit;
  always_comb begin
    w_run  = r_state == RUN;
    w_next = (r_state == INIT && &r_cnt) ? RUN : r_state;
  end
  assign ready = w_run;
  assign w_rd  = w_run & read;
  assign w_wr  = w_run & write;
  assign w_inv = w_run & invalidate;
  // a same-cycle write forwards its data; otherwise a same-cycle invalidate forces a miss
  assign w_hit = w_wr | (~invalidate & r_valid[address]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_cnt      <= '0;
      CT_read    <= 1'b0;
      hit        <= 1'b0;
      CT_address <= '0;
      Mask       <= '0;
    end else begin
      r_state <= w_next;
      if (!w_run) r_cnt <= r_cnt + ADDR_W'(1);
      CT_read <= w_rd;
      if (w_rd) begin
        hit        <= w_hit;
        CT_address <= !w_hit ? '0 : w_wr ? CT_address_in : r_ct_mem[address];
        Mask       <= !w_hit ? '0 : w_wr ? Mask_in : r_mask_mem[address];
      end
    end
  end
  // valid bits are cleared by the INIT sweep rather than by reset, so one clear per cycle
  always_ff @(posedge clk) begin
    if (!w_run) r_valid[r_cnt] <= 1'b0;
    else if (w_wr) r_valid[address] <= 1'b1;
    else if (w_inv) r_valid[address] <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_ct_mem[address]   <= CT_address_in;
      r_mask_mem[address] <= Mask_in;
    end
  end
endmodule

// File: tb/tb_param_translation_table.sv
// tb_param_translation_table: directed vectors plus randomized traffic against a rule-level table model
module tb_param_translation_table;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0, write = 1'b0, invalidate = 1'b0;
  logic [3:0]  address = '0;
  logic [10:0] CT_address_in = '0;
  logic [19:0] Mask_in = '0;
  logic        ready, CT_read, hit;
  logic [10:0] CT_address;
  logic [19:0] Mask;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_translation_table #(.ADDR_W(4), .CT_W(11), .MASK_W(20)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .invalidate(invalidate),
    .address(address), .CT_address_in(CT_address_in), .Mask_in(Mask_in),
    .ready(ready), .CT_read(CT_read), .CT_address(CT_address), .Mask(Mask), .hit(hit)
  );

  // reference: table contents as plain arrays, expected outputs, cycles of INIT remaining
  logic        m_valid [16];
  logic [10:0] m_ct_a [16];
  logic [19:0] m_mk_a [16];
  logic        m_rd, m_hit;
  logic [10:0] m_ct;
  logic [19:0] m_mk;
  int          m_init;

  typedef struct {
    logic rd, wr, inv;
    logic [3:0]  a;
    logic [10:0] ct;
    logic [19:0] mk;
    logic e_rd, e_hit;
    logic [10:0] e_ct;
    logic [19:0] e_mk;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 16;
    m_rd = 1'b0; m_hit = 1'b0; m_ct = '0; m_mk = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic check_model(input string t);
    chk({t, ".ready"}, {31'b0, ready}, {31'b0, m_init == 0});
    chk({t, ".CT_read"}, {31'b0, CT_read}, {31'b0, m_rd});
    chk({t, ".hit"}, {31'b0, hit}, {31'b0, m_hit});
    chk({t, ".CT_address"}, {21'b0, CT_address}, {21'b0, m_ct});
    chk({t, ".Mask"}, {12'b0, Mask}, {12'b0, m_mk});
  endtask

  // drive one cycle of requests, predict the result from the table rules, then step past the edge
  task automatic cycle(input logic rd, input logic wr, input logic inv, input logic [3:0] a,
                       input logic [10:0] ct, input logic [19:0] mk);
    read = rd; write = wr; invalidate = inv; address = a; CT_address_in = ct; Mask_in = mk;
    if (m_init > 0) begin
      m_init--;
      m_rd = 1'b0;
    end else begin
      m_rd = rd;
      if (rd) begin
        if (wr) begin m_hit = 1'b1; m_ct = ct; m_mk = mk; end
        else if (inv || !m_valid[a]) begin m_hit = 1'b0; m_ct = '0; m_mk = '0; end
        else begin m_hit = 1'b1; m_ct = m_ct_a[a]; m_mk = m_mk_a[a]; end
      end
      if (wr) begin m_valid[a] = 1'b1; m_ct_a[a] = ct; m_mk_a[a] = mk; end
      else if (inv) m_valid[a] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000, 1'b1, 1'b0, 11'h000, 20'h00000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'h5, 11'h2AB, 20'hF0F0F, 1'b0, 1'b0, 11'h000, 20'h00000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000, 1'b1, 1'b1, 11'h2AB, 20'hF0F0F};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000, 1'b0, 1'b1, 11'h2AB, 20'hF0F0F};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'h9, 11'h000, 20'h00000, 1'b1, 1'b0, 11'h000, 20'h00000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h3, 11'h011, 20'h12345, 1'b1, 1'b1, 11'h011, 20'h12345};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'h7, 11'h100, 20'hABCDE, 1'b0, 1'b1, 11'h011, 20'h12345};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h7, 11'h000, 20'h00000, 1'b1, 1'b1, 11'h100, 20'hABCDE};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h7, 11'h000, 20'h00000, 1'b0, 1'b1, 11'h100, 20'hABCDE};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h7, 11'h000, 20'h00000, 1'b1, 1'b0, 11'h000, 20'h00000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'hA, 11'h055, 20'h00055, 1'b0, 1'b0, 11'h000, 20'h00000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'hA, 11'h000, 20'h00000, 1'b1, 1'b0, 11'h000, 20'h00000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000, 1'b1, 1'b1, 11'h2AB, 20'hF0F0F};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h3, 11'h000, 20'h00000, 1'b1, 1'b1, 11'h011, 20'h12345};
    model_reset();
    #12;
    check_model("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // INIT with read held high and a write attempted: nothing may happen for 16 cycles
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'h5, 11'h7FF, 20'hFFFFF);
      chk($sformatf("init%0d.ready", i), {31'b0, ready}, {31'b0, i == 15});
      chk($sformatf("init%0d.CT_read", i), {31'b0, CT_read}, 32'd0);
    end
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rd, vecs[i].wr, vecs[i].inv, vecs[i].a, vecs[i].ct, vecs[i].mk);
      chk($sformatf("vec%0d.ready", i), {31'b0, ready}, 32'd1);
      chk($sformatf("vec%0d.CT_read", i), {31'b0, CT_read}, {31'b0, vecs[i].e_rd});
      chk($sformatf("vec%0d.hit", i), {31'b0, hit}, {31'b0, vecs[i].e_hit});
      chk($sformatf("vec%0d.CT_address", i), {21'b0, CT_address}, {21'b0, vecs[i].e_ct});
      chk($sformatf("vec%0d.Mask", i), {12'b0, Mask}, {12'b0, vecs[i].e_mk});
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)), 11'($urandom), 20'($urandom));
      check_model($sformatf("rand%0d", i));
    end
    // reset asserted mid-cycle while a hit result is on the outputs
    cycle(1'b0, 1'b1, 1'b0, 4'h5, 11'h2AB, 20'hF0F0F);
    cycle(1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000);
    check_model("prerst");
    read = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_model("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000);
      check_model($sformatf("reinit%0d", i));
    end
    // second reset in the middle of the sweep restarts it from index 0
    rst = 1'b1;
    model_reset();
    #1;
    check_model("rst_midinit");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000);
      chk($sformatf("reinit2_%0d.ready", i), {31'b0, ready}, {31'b0, i == 15});
      check_model($sformatf("reinit2_%0d", i));
    end
    cycle(1'b1, 1'b0, 1'b0, 4'h5, 11'h000, 20'h00000);
    chk("post_rst_read5.CT_read", {31'b0, CT_read}, 32'd1);
    chk("post_rst_read5.hit", {31'b0, hit}, 32'd0);
    check_model("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
